// File: rtl/avr_timer_pkg.sv
// Shared definitions for the AVR 8-bit I/O timer: register offsets, clock-select
// and compare-output encodings, and control/flag bit positions.
package avr_timer_pkg;

  localparam logic [1:0] TCNT_OFS = 2'd0;
  localparam logic [1:0] OCR_OFS  = 2'd1;
  localparam logic [1:0] TCCR_OFS = 2'd2;
  localparam logic [1:0] TIFR_OFS = 2'd3;

  typedef enum logic [2:0] {
    CS_STOP    = 3'd0,
    CS_DIV1    = 3'd1,
    CS_DIV8    = 3'd2,
    CS_DIV64   = 3'd3,
    CS_DIV256  = 3'd4,
    CS_DIV1024 = 3'd5,
    CS_STOP6   = 3'd6,
    CS_STOP7   = 3'd7
  } cs_e;

  typedef enum logic [1:0] {
    COM_OFF    = 2'd0,
    COM_TOGGLE = 2'd1,
    COM_PWM    = 2'd2,
    COM_SET    = 2'd3
  } com_e;

  localparam int TCCR_CTC     = 3;
  localparam int TCCR_OCIE    = 4;
  localparam int TCCR_TOIE    = 5;
  localparam int TCCR_COM_LSB = 6;

  localparam int TIFR_TOV = 0;
  localparam int TIFR_OCF = 1;

endpackage

// File: rtl/avr_timer_prescaler.sv
// Free-running 10-bit prescaler; emits a one-cycle tick when the low bits for
// the selected divide ratio are all ones.
module avr_timer_prescaler
  import avr_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic [2:0] cs,
  output logic       tick
);

  logic [9:0] presc_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
    end else if (clear) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 10'd1;
    end
  end

  always_comb begin
    tick = 1'b0;
    case (cs_e'(cs))
      CS_DIV1:    tick = 1'b1;
      CS_DIV8:    tick = &presc_reg[2:0];
      CS_DIV64:   tick = &presc_reg[5:0];
      CS_DIV256:  tick = &presc_reg[7:0];
      CS_DIV1024: tick = &presc_reg[9:0];
      default:    tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/avr_io_timer8.sv
// AVR I/O-bus 8-bit timer/counter with output compare, overflow/compare flags
// and a two-source interrupt. Define AVR_TIMER_PWM_EN to add the oc output pin.
module avr_io_timer8
  import avr_timer_pkg::*;
#(
  parameter logic [5:0] BASE_ADDR = 6'h00,
  parameter logic [1:0] VEC_OCF   = 2'd1,
  parameter logic [1:0] VEC_TOV   = 2'd2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] io_a,
  input  logic       io_re,
  input  logic       io_we,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       irq,
  output logic [1:0] ivect,
`ifdef AVR_TIMER_PWM_EN
  input  logic       ieack,
  output logic       oc
`else
  input  logic       ieack
`endif
);

`ifdef AVR_TIMER_PWM_EN
  localparam logic [7:0] TCCR_WMASK = 8'hFF;
`else
  localparam logic [7:0] TCCR_WMASK = 8'h3F;
`endif

  logic [6:0] addr_diff;
  logic       hit;
  logic [1:0] reg_sel;
  logic       wr_tcnt, wr_ocr, wr_tccr, wr_tifr;
  logic [7:0] tcnt_reg, tcnt_next;
  logic [7:0] ocr_reg, ocr_next;
  logic [7:0] tccr_reg, tccr_next;
  logic [1:0] tifr_reg, tifr_next;
  logic       tick, count_en, match, ctc;
  logic       ocf_set, tov_set, ocf_int, tov_int;
  logic [1:0] set_vec, w1c_vec, ack_vec;

  // A negative difference sets bit 6, so one test covers both range bounds.
  assign addr_diff = {1'b0, io_a} - {1'b0, BASE_ADDR};
  assign hit       = (addr_diff[6:2] == 5'd0);
  assign reg_sel   = addr_diff[1:0];

  assign wr_tcnt = io_we && hit && (reg_sel == TCNT_OFS);
  assign wr_ocr  = io_we && hit && (reg_sel == OCR_OFS);
  assign wr_tccr = io_we && hit && (reg_sel == TCCR_OFS);
  assign wr_tifr = io_we && hit && (reg_sel == TIFR_OFS);

  avr_timer_prescaler u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wr_tccr),
    .cs      (tccr_reg[2:0]),
    .tick    (tick)
  );

  // A CPU write to TCNT overrides the tick entirely, including compare/overflow.
  assign count_en = tick && !wr_tcnt;
  assign match    = (tcnt_reg == ocr_reg);
  assign ctc      = tccr_reg[TCCR_CTC];
  assign ocf_set  = count_en && match;
  assign tov_set  = count_en && (tcnt_reg == 8'hFF) && (!ctc || (ocr_reg == 8'hFF));

  always_comb begin
    tcnt_next = tcnt_reg;
    if (wr_tcnt) begin
      tcnt_next = io_wdata;
    end else if (count_en) begin
      if (match && ctc) begin
        tcnt_next = 8'h00;
      end else begin
        tcnt_next = tcnt_reg + 8'd1;
      end
    end
  end

  assign ocr_next  = wr_ocr  ? io_wdata : ocr_reg;
  assign tccr_next = wr_tccr ? (io_wdata & TCCR_WMASK) : tccr_reg;

  assign ocf_int = tifr_reg[TIFR_OCF] && tccr_reg[TCCR_OCIE];
  assign tov_int = tifr_reg[TIFR_TOV] && tccr_reg[TCCR_TOIE];
  assign irq     = ocf_int || tov_int;
  assign ivect   = ocf_int ? VEC_OCF : (tov_int ? VEC_TOV : 2'd0);

  always_comb begin
    set_vec           = '0;
    ack_vec           = '0;
    set_vec[TIFR_OCF] = ocf_set;
    set_vec[TIFR_TOV] = tov_set;
    ack_vec[TIFR_OCF] = ieack && ocf_int;
    ack_vec[TIFR_TOV] = ieack && !ocf_int && tov_int;
  end
  assign w1c_vec = wr_tifr ? io_wdata[1:0] : 2'b00;

  // Hardware set always beats a software or acknowledge clear in the same cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_flag
    assign tifr_next[gi] = set_vec[gi] | (tifr_reg[gi] & ~w1c_vec[gi] & ~ack_vec[gi]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_reg <= '0;
      ocr_reg  <= '0;
      tccr_reg <= '0;
      tifr_reg <= '0;
    end else begin
      tcnt_reg <= tcnt_next;
      ocr_reg  <= ocr_next;
      tccr_reg <= tccr_next;
      tifr_reg <= tifr_next;
    end
  end

  always_comb begin
    io_rdata = 8'h00;
    if (io_re && hit) begin
      case (reg_sel)
        TCNT_OFS: io_rdata = tcnt_reg;
        OCR_OFS:  io_rdata = ocr_reg;
        TCCR_OFS: io_rdata = tccr_reg;
        default:  io_rdata = {6'b0, tifr_reg};
      endcase
    end
  end

`ifdef AVR_TIMER_PWM_EN
  logic oc_reg, oc_next;

  always_comb begin
    oc_next = oc_reg;
    case (com_e'(tccr_reg[TCCR_COM_LSB +: 2]))
      COM_OFF:    oc_next = 1'b0;
      COM_TOGGLE: oc_next = oc_reg ^ ocf_set;
      COM_PWM:    oc_next = (tcnt_reg < ocr_reg);
      default:    oc_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oc_reg <= 1'b0;
    end else begin
      oc_reg <= oc_next;
    end
  end

  assign oc = oc_reg;
`endif

endmodule

// File: tb/tb_avr_io_timer8.sv
// Scoreboard bench for avr_io_timer8: a behavioural model predicts every read
// (data, irq, ivect and oc when built with AVR_TIMER_PWM_EN); a monitor checks.
module tb_avr_io_timer8;

  localparam logic [5:0] BASE = 6'h04;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] io_a = '0;
  logic       io_re = 1'b0;
  logic       io_we = 1'b0;
  logic [7:0] io_wdata = '0;
  logic [7:0] io_rdata;
  logic       irq;
  logic [1:0] ivect;
  logic       ieack = 1'b0;
`ifdef AVR_TIMER_PWM_EN
  logic       oc;
`endif

  always #5 clk = ~clk;

  avr_io_timer8 #(.BASE_ADDR(BASE), .VEC_OCF(2'd1), .VEC_TOV(2'd2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .io_a     (io_a),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .irq      (irq),
    .ivect    (ivect),
`ifdef AVR_TIMER_PWM_EN
    .ieack    (ieack),
    .oc       (oc)
`else
    .ieack    (ieack)
`endif
  );

  typedef struct {
    logic [5:0] a;
    logic [7:0] rdata;
    logic       irq;
    logic [1:0] ivect;
    logic       oc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;

  // Reference model state, kept as plain integers.
  int m_tcnt, m_ocr, m_tccr, m_ocf, m_tov, m_oc, m_phase;
  int divs[8] = '{0, 1, 8, 64, 256, 1024, 0, 0};
`ifdef AVR_TIMER_PWM_EN
  int tccr_mask = 255;
`else
  int tccr_mask = 63;
`endif

  function automatic void model_reset();
    m_tcnt = 0; m_ocr = 0; m_tccr = 0; m_ocf = 0; m_tov = 0; m_oc = 0; m_phase = 0;
  endfunction

  function automatic bit model_tick();
    int div = divs[m_tccr % 8];
    return (div != 0) && ((m_phase % div) == div - 1);
  endfunction

  function automatic int model_ivect();
    if (m_ocf == 1 && ((m_tccr >> 4) & 1) == 1) return 1;
    if (m_tov == 1 && ((m_tccr >> 5) & 1) == 1) return 2;
    return 0;
  endfunction

  function automatic bit in_range(input int a);
    return (a >= BASE) && (a < BASE + 4);
  endfunction

  function automatic int model_read(input int a);
    if (!in_range(a)) return 0;
    case (a - BASE)
      0: return m_tcnt;
      1: return m_ocr;
      2: return m_tccr;
      default: return m_ocf * 2 + m_tov;
    endcase
  endfunction

  function automatic void model_step(input bit we, input int a, input int d, input bit ack);
    bit hit = we && in_range(a);
    int ofs = a - BASE;
    bit ctc = ((m_tccr >> 3) & 1) == 1;
    int com = (m_tccr >> 6) & 3;
    int iv = model_ivect();
    bit ocf_set = 0;
    bit tov_set = 0;
    int nt = m_tcnt;
    int n_oc = m_oc;
    if (model_tick()) begin
      ocf_set = (m_tcnt == m_ocr);
      tov_set = (m_tcnt == 255) && (!ctc || m_ocr == 255);
      if (ctc && m_tcnt == m_ocr) nt = 0;
      else nt = (m_tcnt + 1) % 256;
    end
    if (hit && ofs == 0) begin
      nt = d; ocf_set = 0; tov_set = 0;
    end
    case (com)
      0: n_oc = 0;
      1: n_oc = ocf_set ? 1 - m_oc : m_oc;
      2: n_oc = (m_tcnt < m_ocr) ? 1 : 0;
      default: n_oc = 1;
    endcase
    if (hit && ofs == 3 && (d & 2) != 0) m_ocf = 0;
    if (hit && ofs == 3 && (d & 1) != 0) m_tov = 0;
    if (ack && iv == 1) m_ocf = 0;
    if (ack && iv == 2) m_tov = 0;
    if (ocf_set) m_ocf = 1;
    if (tov_set) m_tov = 1;
    if (hit && ofs == 1) m_ocr = d;
    if (hit && ofs == 2) begin
      m_tccr = d & tccr_mask;
      m_phase = 0;
    end else begin
      m_phase = (m_phase + 1) % 1024;
    end
    m_tcnt = nt;
    m_oc = n_oc;
  endfunction

  // One bus cycle: drive just after the rising edge, predict, then advance the model.
  task automatic cycle(input bit rst, input bit re, input bit we, input logic [5:0] a,
                       input logic [7:0] d, input bit ack);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rst; io_re = re; io_we = we; io_a = a; io_wdata = d; ieack = ack;
    if (!rst) model_reset();
    if (re) begin
      e.a = a;
      e.rdata = 8'(model_read(int'(a)));
      e.irq = (model_ivect() != 0);
      e.ivect = 2'(model_ivect());
      e.oc = (m_oc != 0);
      sb.push_back(e);
    end
    if (rst) model_step(we, int'(a), int'(d), ack);
  endtask

  task automatic wr(input int ofs, input logic [7:0] d);
    cycle(1, 0, 1, BASE + 6'(ofs), d, 0);
  endtask

  task automatic rd(input int ofs);
    cycle(1, 1, 0, BASE + 6'(ofs), 8'h00, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1, 0, 0, 6'h00, 8'h00, 0);
  endtask

  task automatic ack_rd(input int ofs);
    cycle(1, 1, 0, BASE + 6'(ofs), 8'h00, 1);
  endtask

  always @(negedge clk) begin
    if (io_re) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_underflow: read at a=%h with no expected entry", io_a);
      end else begin
        mon_e = sb.pop_front();
        if (io_rdata !== mon_e.rdata || irq !== mon_e.irq || ivect !== mon_e.ivect
`ifdef AVR_TIMER_PWM_EN
            || oc !== mon_e.oc
`endif
           ) begin
          fails++;
          $display("FAIL read a=%h: got rdata=%h irq=%b ivect=%0d oc=%b, want rdata=%h irq=%b ivect=%0d oc=%b",
                   mon_e.a, io_rdata, irq, ivect,
`ifdef AVR_TIMER_PWM_EN
                   oc,
`else
                   1'b0,
`endif
                   mon_e.rdata, mon_e.irq, mon_e.ivect, mon_e.oc);
        end else begin
          $display("[TB] t=%0t rd a=%h rdata=%h irq=%b ivect=%0d", $time, mon_e.a, io_rdata, irq, ivect);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    int ofs;
    model_reset();

    // Reads during reset, including out-of-range addresses.
    cycle(0, 1, 0, BASE, 8'h00, 0);
    cycle(0, 1, 0, BASE + 6'd3, 8'h00, 0);
    cycle(0, 1, 0, BASE - 6'd1, 8'h00, 0);
    cycle(1, 1, 0, BASE + 6'd2, 8'h00, 0);
    for (int i = 0; i < 4; i++) rd(i);

    // Free-running at clk/1.
    wr(2, 8'h01);
    idle(10);
    rd(0);
    cycle(1, 1, 0, BASE + 6'd4, 8'h00, 0);

    // CTC with compare interrupt, then acknowledge.
    wr(2, 8'h00); wr(0, 8'h00); wr(1, 8'h04); wr(2, 8'h19);
    for (int i = 0; i < 8; i++) rd(0);
    rd(3);
    ack_rd(3);
    rd(3);

    // Overflow interrupt and W1C clear.
    wr(2, 8'h00); wr(3, 8'h03); wr(0, 8'hFE); wr(2, 8'h21);
    rd(0); rd(0); rd(3);
    wr(2, 8'h20);
    rd(3); wr(3, 8'h01); rd(3);

    // Both flags pending: compare wins, then overflow after acknowledge.
    wr(2, 8'h00); wr(3, 8'h03); wr(1, 8'hFF); wr(0, 8'hFD); wr(2, 8'h39);
    idle(3);
    wr(2, 8'h38);
    rd(3); ack_rd(3); rd(3); ack_rd(3); rd(3);
    ack_rd(3);

    // Divide by 64, TCCR rewrite mid-period, TCNT write on a tick cycle.
    wr(3, 8'h03); wr(0, 8'h00); wr(2, 8'h03);
    for (int i = 0; i < 140; i++) rd(0);
    idle(30);
    wr(2, 8'h03);
    for (int i = 0; i < 70; i++) rd(0);
    for (int k = 0; k < 70 && !model_tick(); k++) idle(1);
    wr(0, 8'h10);
    rd(0); rd(0);

`ifdef AVR_TIMER_PWM_EN
    // Fast PWM at OCR=0x40 over two counter periods.
    wr(2, 8'h00); wr(1, 8'h40); wr(0, 8'h00); wr(2, 8'h81);
    for (int i = 0; i < 520; i++) rd(0);
`endif

    // Randomized traffic across and around the register window.
    for (int i = 0; i < 1500; i++) begin
      ofs = $urandom_range(0, 7) - 2;
      d = 8'($urandom);
      if (ofs == 2 && $urandom_range(0, 3) != 0) d[2:0] = 3'($urandom_range(1, 3));
      if (ofs == 1 && $urandom_range(0, 1) == 1) d = 8'($urandom_range(0, 15));
      cycle(1, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
            6'(int'(BASE) + ofs), d, $urandom_range(0, 11) == 0);
    end

    // Asynchronous reset mid-count, then more random traffic.
    wr(2, 8'h31);
    idle(5);
    cycle(0, 1, 0, BASE, 8'h00, 0);
    cycle(0, 1, 0, BASE + 6'd3, 8'h00, 0);
    cycle(1, 1, 0, BASE + 6'd2, 8'h00, 0);
    for (int i = 0; i < 500; i++) begin
      ofs = $urandom_range(0, 7) - 2;
      d = 8'($urandom);
      if (ofs == 2) d[2:0] = 3'($urandom_range(0, 5));
      cycle(1, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
            6'(int'(BASE) + ofs), d, $urandom_range(0, 9) == 0);
    end

    idle(2);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
